// File: rtl/hamming_ser_if.sv
// hamming_ser_if: codeword handshake between the Hamming encoder stage
// (master) and the serializer (slave).
interface hamming_ser_if;
  logic [11:0] code_in;
  logic        in_valid;
  logic        in_ready;

  modport master (output code_in, output in_valid, input in_ready);
  modport slave  (input code_in, input in_valid, output in_ready);
endinterface

// File: rtl/hamming_ser.sv
// hamming_ser: serializes a Hamming(12,8) codeword onto an idle-high line.
// Frame: start bit (0), 12 codeword bits LSB first, optional even-parity
// bit, stop bit (1). Each bit lasts BIT_CYCLES clocks.
// Optional feature macro: HAMMING_SER_PARITY_EN adds the parity bit (PAR state).
//
// state | meaning
// IDLE  | line high, in_ready=1, waiting for a codeword
// START | start bit (0)
// DATA  | codeword bit r_idx
// PAR   | XOR of the 12 latched bits (only with HAMMING_SER_PARITY_EN)
// STOP  | stop bit (1); done pulses on its last cycle
module hamming_ser #(
  parameter int BIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  hamming_ser_if.slave       s_if,
  output logic               ser_out,
  output logic               busy,
  output logic               done
);

`ifdef HAMMING_SER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [7:0] LP_LAST = 8'(BIT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_idx;
  logic [11:0] r_code;
  logic        r_ser;
  logic        r_busy;
  logic        r_done;
  logic        r_ready;

  logic        w_cnt_last;
  logic [7:0]  w_cnt_nxt;
  logic [3:0]  w_idx_nxt;

  assign w_cnt_last = (r_cnt == LP_LAST);
  assign w_cnt_nxt  = r_cnt + 8'd1;
  assign w_idx_nxt  = r_idx + 4'd1;

  assign ser_out       = r_ser;
  assign busy          = r_busy;
  assign done          = r_done;
  assign s_if.in_ready = r_ready;

  // Frame sequencer; every output is registered so it reflects the state
  // being entered, which puts the start bit in the cycle right after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_code  <= '0;
      r_ser   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_if.in_valid && r_ready) begin
            r_code  <= s_if.code_in;
            r_state <= START;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ser   <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        START: begin
          if (w_cnt_last) begin
            r_state <= DATA;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ser   <= r_code[0];
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        DATA: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (r_idx == 4'd11) begin
              r_idx <= '0;
`ifdef HAMMING_SER_PARITY_EN
              r_state <= PAR;
              r_ser   <= ^r_code;
`else
              r_state <= STOP;
              r_ser   <= 1'b1;
              // With one cycle per bit the first stop cycle is also the last.
              r_done  <= (LP_LAST == 8'd0);
`endif
            end else begin
              r_idx <= w_idx_nxt;
              r_ser <= r_code[w_idx_nxt];
            end
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
`ifdef HAMMING_SER_PARITY_EN
        PAR: begin
          if (w_cnt_last) begin
            r_state <= STOP;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ser   <= 1'b1;
            r_done  <= (LP_LAST == 8'd0);
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
`endif
        STOP: begin
          if (w_cnt_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ser   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt  <= w_cnt_nxt;
            r_done <= (w_cnt_nxt == LP_LAST);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_ser   <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
